mips_fetch_ctrl: RTL and testbench

MIPS_FETCH_CTRL -- requirements
Module: mips_fetch_ctrl

---
 rtl/mips_fetch_ctrl.sv | 78 +++++++
 tb/tb_mips_fetch_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_ctrl.sv
// rtl/mips_fetch_ctrl.sv - instruction fetch controller for a synchronous-read instruction ROM
// Issues one word address per edge and delivers the word read on the previous edge.
module mips_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [31:0]       br_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       inst_code,
  output logic [31:0]       inst_pc,
  output logic              inst_valid,
  output logic [15:0]       fetch_cnt
);

  localparam logic [31:0] PC_MASK = ((32'd1 << (ADDR_W + 2)) - 32'd1) & ~32'd3;
  localparam logic [31:0] BOOT_PC = RESET_PC & PC_MASK;

  typedef enum logic [1:0] {BOOT, RUN, STALL, HALT} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] issued_pc;
  logic        issued_vld;
  logic [31:0] next_pc;

  // Address issued this edge when not stalled; a redirect bypasses fetch_pc.
  assign next_pc = (br_valid ? br_target : fetch_pc) & PC_MASK;

  // While stalled the ROM re-reads the in-flight word so rom_data stays valid.
  always_comb begin
    rom_addr = BOOT_PC[ADDR_W+1:2];
    if (rst) begin
      if (stall) rom_addr = issued_pc[ADDR_W+1:2];
      else       rom_addr = next_pc[ADDR_W+1:2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= BOOT;
      fetch_pc   <= BOOT_PC;
      issued_pc  <= 32'd0;
      issued_vld <= 1'b0;
      inst_code  <= 32'd0;
      inst_pc    <= 32'd0;
      inst_valid <= 1'b0;
      fetch_cnt  <= 16'd0;
    end else begin
      case (state)
        HALT: begin
          inst_valid <= 1'b0;
        end
        default: begin
          if (stall) begin
            state <= STALL;
          end else begin
            issued_pc  <= next_pc;
            issued_vld <= !halt;
            fetch_pc   <= (next_pc + 32'd4) & PC_MASK;
            inst_code  <= rom_data;
            inst_pc    <= issued_pc;
            inst_valid <= issued_vld;
            if (issued_vld && fetch_cnt != 16'hFFFF)
              fetch_cnt <= fetch_cnt + 16'd1;
            state <= halt ? HALT : RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch_ctrl.sv
// tb/tb_mips_fetch_ctrl.sv - self-checking bench for mips_fetch_ctrl
// A queue of in-flight addresses models the fetch pipe; directed scenarios then random traffic.
module tb_mips_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        halt = 1'b0;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data = 32'd0;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic [15:0] fetch_cnt;

  int passed = 0;
  int total  = 0;

  mips_fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_target(br_target),
    .halt(halt), .rom_addr(rom_addr), .rom_data(rom_data), .inst_code(inst_code),
    .inst_pc(inst_pc), .inst_valid(inst_valid), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  // ROM word k holds 0x1000_0000 + k, read data valid one edge after the address.
  always_ff @(posedge clk) rom_data <= 32'h1000_0000 + {26'd0, rom_addr};

  // Reference model state
  logic [31:0] q[$];
  logic [31:0] m_next, m_last;
  bit          m_halted;
  logic [31:0] e_code, e_pc;
  bit          e_valid;
  int          e_cnt;
  logic [31:0] addr_seen;

  function automatic logic [31:0] msk(input logic [31:0] x);
    return x & 32'h0000_00FC;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_next = 32'd0; m_last = 32'd0; m_halted = 0;
    e_code = 32'd0; e_pc = 32'd0; e_valid = 0; e_cnt = 0;
  endtask

  task automatic model_edge();
    logic [31:0] a;
    if (m_halted) begin
      e_valid = 0;
    end else if (!stall) begin
      a = msk(br_valid ? br_target : m_next);
      if (q.size() > 0) begin
        e_pc    = q.pop_front();
        e_code  = 32'h1000_0000 + (e_pc >> 2);
        e_valid = 1;
        if (e_cnt < 65535) e_cnt++;
      end else begin
        e_valid = 0;
      end
      m_last = a;
      m_next = msk(a + 32'd4);
      if (halt) m_halted = 1;
      else      q.push_back(a);
    end
  endtask

  task automatic cyc(input bit s, input bit b, input logic [31:0] t, input bit h);
    logic [31:0] ea;
    stall = s; br_valid = b; br_target = t; halt = h;
    #1;
    addr_seen = {26'd0, rom_addr};
    if (!m_halted) begin
      ea = stall ? m_last : msk(br_valid ? br_target : m_next);
      check("rom_addr", addr_seen, {26'd0, ea[7:2]});
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("inst_valid", {31'd0, inst_valid}, {31'd0, e_valid});
    check("fetch_cnt", {16'd0, fetch_cnt}, e_cnt[31:0]);
    if (e_valid) begin
      check("inst_pc", inst_pc, e_pc);
      check("inst_code", inst_code, e_code);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'd0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 0; br_valid = 0; halt = 0;
    #1;
    model_reset();
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_cnt", {16'd0, fetch_cnt}, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_addr", {26'd0, rom_addr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Basic sequence after reset
    do_reset();
    idle(1);
    check("boot_e1_valid", {31'd0, inst_valid}, 32'd0);
    idle(1);
    check("e2_pc", inst_pc, 32'h00); check("e2_code", inst_code, 32'h1000_0000);
    check("e2_cnt", {16'd0, fetch_cnt}, 32'd1);
    idle(1);
    check("e3_pc", inst_pc, 32'h04); check("e3_code", inst_code, 32'h1000_0001);
    check("e3_cnt", {16'd0, fetch_cnt}, 32'd2);
    idle(1);
    check("e4_pc", inst_pc, 32'h08); check("e4_code", inst_code, 32'h1000_0002);
    check("e4_cnt", {16'd0, fetch_cnt}, 32'd3);

    // Stall with inst_pc = 0x08
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 32'd0, 0);
      check("stall_addr", addr_seen, 32'd3);
      check("stall_pc", inst_pc, 32'h08);
      check("stall_cnt", {16'd0, fetch_cnt}, 32'd3);
    end
    idle(1);
    check("rel1_pc", inst_pc, 32'h0C); check("rel1_cnt", {16'd0, fetch_cnt}, 32'd4);
    idle(1);
    check("rel2_pc", inst_pc, 32'h10); check("rel2_cnt", {16'd0, fetch_cnt}, 32'd5);

    // Redirect with delay slot
    do_reset();
    idle(4);
    check("br_pre_pc", inst_pc, 32'h08);
    cyc(0, 1, 32'h20, 0);
    check("br_addr", addr_seen, 32'd8);
    check("br_slot_pc", inst_pc, 32'h0C);
    idle(1);
    check("br_tgt_pc", inst_pc, 32'h20); check("br_tgt_code", inst_code, 32'h1000_0008);
    idle(1);
    check("br_next_pc", inst_pc, 32'h24);

    // Wrap and masked redirect target
    do_reset();
    idle(65);
    check("wrap_fc_pc", inst_pc, 32'hFC); check("wrap_fc_code", inst_code, 32'h1000_003F);
    idle(1);
    check("wrap_00_pc", inst_pc, 32'h00); check("wrap_00_code", inst_code, 32'h1000_0000);
    cyc(0, 1, 32'hFFFF_FF06, 0);
    check("mask_addr", addr_seen, 32'd1);
    idle(1);
    check("mask_pc", inst_pc, 32'h04); check("mask_code", inst_code, 32'h1000_0001);

    // Stall beats redirect, then halt
    do_reset();
    idle(4);
    cyc(1, 1, 32'h40, 0);
    idle(1);
    check("nobr_pc", inst_pc, 32'h0C);
    cyc(0, 0, 32'd0, 1);
    check("halt_pc", inst_pc, 32'h10); check("halt_valid", {31'd0, inst_valid}, 32'd1);
    check("halt_cnt", {16'd0, fetch_cnt}, 32'd5);
    for (int i = 0; i < 5; i++) begin
      cyc(i[0], 1, 32'h80, i[1]);
      check("halted_valid", {31'd0, inst_valid}, 32'd0);
      check("halted_cnt", {16'd0, fetch_cnt}, 32'd5);
    end

    // Asynchronous reset between edges
    do_reset();
    idle(6);
    #2 rst = 1'b0;
    #1;
    check("async_valid", {31'd0, inst_valid}, 32'd0);
    check("async_code", inst_code, 32'd0);
    check("async_cnt", {16'd0, fetch_cnt}, 32'd0);
    check("async_addr", {26'd0, rom_addr}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    check("restart_pc", inst_pc, 32'h00); check("restart_cnt", {16'd0, fetch_cnt}, 32'd1);

    // Random traffic
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 150; i++)
        cyc(($urandom % 4) == 0, ($urandom % 7) == 0, $urandom, ($urandom % 120) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
